// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers and index type.
// Imported by fetch, decode/write-back and execute so all stages agree on encodings.
package y86_pkg;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t RNONE = 4'hF;
    localparam reg_idx_t RRSP  = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/regfile_15x64.sv
// 15 x 64-bit register file: two async operand reads, one async debug read,
// two synchronous write ports (E and M) with M winning on a shared index.
module regfile_15x64
    import y86_pkg::*;
#(
    parameter int NREG = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr_a,
    input  logic [3:0]  addr_b,
    input  logic [3:0]  addr_dbg,
    output logic [63:0] data_a,
    output logic [63:0] data_b,
    output logic [63:0] data_dbg,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    localparam reg_idx_t LAST = reg_idx_t'(NREG - 1);

    logic [63:0] regs [NREG];

    // NOTE: this storage is architectural state that must read 0 after reset, so
    // every entry is cleared; plain data memories normally carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking writes; the M write is scheduled last, so on a
            // shared index it is the value that lands.
            if (we_e && dst_e <= LAST) begin
                regs[dst_e] <= val_e;
            end
            if (we_m && dst_m <= LAST) begin
                regs[dst_m] <= val_m;
            end
        end
    end

    // Index 4'hF has no storage behind it and reads as zero.
    assign data_a   = (addr_a   <= LAST) ? regs[addr_a]   : '0;
    assign data_b   = (addr_b   <= LAST) ? regs[addr_b]   : '0;
    assign data_dbg = (addr_dbg <= LAST) ? regs[addr_dbg] : '0;

endmodule

// File: rtl/regfile_decode_wb.sv
// Y86-64 SEQ decode/write-back: selects source/destination indices from icode,
// reads operands combinationally and commits valE/valM on wb_en edges.
module regfile_decode_wb
    import y86_pkg::*;
#(
    parameter int NREG    = 15,
    parameter int RSP_IDX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data
);

    localparam reg_idx_t RSP = reg_idx_t'(RSP_IDX);

    logic [63:0] rd_a;
    logic [63:0] rd_b;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            I_RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            I_POPQ: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    regfile_15x64 #(.NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .addr_a   (srcA),
        .addr_b   (srcB),
        .addr_dbg (dbg_addr),
        .data_a   (rd_a),
        .data_b   (rd_b),
        .data_dbg (dbg_data),
        .we_e     (wb_en && dstE != RNONE),
        .dst_e    (dstE),
        .val_e    (valE),
        .we_m     (wb_en && dstM != RNONE),
        .dst_m    (dstM),
        .val_m    (valM)
    );

    assign valA = (srcA == RNONE) ? '0 : rd_a;
    assign valB = (srcB == RNONE) ? '0 : rd_b;

endmodule

// File: tb/tb_regfile_decode_wb.sv
// Self-checking bench for regfile_decode_wb: directed scenarios plus randomized
// instruction stream checked against an array-based reference model.
module tb_regfile_decode_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode, rA, rB, dbg_addr;
    logic        cnd, wb_en;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB, dbg_data;
    logic [3:0]  srcA, srcB, dstE, dstM;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0] model [15];

    always #5 clk = ~clk;

    regfile_decode_wb dut (
        .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en), .valA(valA), .valB(valB),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference decode rules, written as instruction-class membership.
    function automatic logic [3:0] ref_srca(logic [3:0] ic, logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_srcb(logic [3:0] ic, logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dste(logic [3:0] ic, logic [3:0] rb, logic c);
        if ((ic == 4'h2 && c) || ic inside {4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dstm(logic [3:0] ic, logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    function automatic logic [63:0] ref_read(logic [3:0] idx);
        return (idx == 4'hF) ? 64'd0 : model[idx];
    endfunction

    // Apply the current inputs to the model, then advance one rising edge.
    task automatic tick();
        logic [3:0] e, m;
        if (rst) begin
            for (int i = 0; i < 15; i++) model[i] = '0;
        end else if (wb_en) begin
            e = ref_dste(icode, rB, cnd);
            m = ref_dstm(icode, rA);
            if (e != 4'hF) model[e] = valE;
            if (m != 4'hF) model[m] = valM;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb, logic c,
                         logic [63:0] ve, logic [63:0] vm, logic we);
        icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; wb_en = we;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'h6, 4'h1, 4'h2, 1'b0, 64'h5555, 64'h6666, 1'b1);
        tick();
        rst = 1'b0;
        drive(4'h6, 4'h1, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
        total_cnt++;
        if (valA !== 64'd0 || valB !== 64'd0)
            $display("FAIL reset_operands: valA=%h valB=%h required 0", valA, valB);
        else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            dbg_addr = 4'(a);
            #1;
            total_cnt++;
            if (dbg_data !== 64'd0)
                $display("FAIL reset_dbg[%0d]: got %h required 0", a, dbg_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_irmovq();
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1);
        total_cnt++;
        if (valB !== 64'd0 || dstE !== 4'h2)
            $display("FAIL irmovq_pre: valB=%h dstE=%h required 0/2", valB, dstE);
        else pass_cnt++;
        tick();
        dbg_addr = 4'h2; #1;
        total_cnt++;
        if (dbg_data !== 64'h1234)
            $display("FAIL irmovq_post: R[2]=%h required 1234", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_cmov();
        drive(4'h2, 4'h2, 4'h3, 1'b0, 64'h1234, 64'h0, 1'b1);
        total_cnt++;
        if (dstE !== 4'hF || srcA !== 4'h2)
            $display("FAIL cmov_nc_idx: dstE=%h srcA=%h required F/2", dstE, srcA);
        else pass_cnt++;
        tick();
        dbg_addr = 4'h3; #1;
        total_cnt++;
        if (dbg_data !== 64'd0)
            $display("FAIL cmov_nc: R[3]=%h required 0", dbg_data);
        else pass_cnt++;
        drive(4'h2, 4'h2, 4'h3, 1'b1, 64'h1234, 64'h0, 1'b1);
        tick();
        total_cnt++;
        if (dbg_data !== 64'h1234)
            $display("FAIL cmov_c: R[3]=%h required 1234", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_pushq();
        drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 1'b1);
        tick();
        drive(4'hA, 4'h2, 4'hF, 1'b0, 64'hF8, 64'h0, 1'b1);
        total_cnt++;
        if (srcA !== 4'h2 || srcB !== 4'h4 || valB !== 64'h100 || valA !== 64'h1234)
            $display("FAIL pushq_pre: srcA=%h srcB=%h valA=%h valB=%h required 2/4/1234/100",
                     srcA, srcB, valA, valB);
        else pass_cnt++;
        tick();
        dbg_addr = 4'h4; #1;
        total_cnt++;
        if (dbg_data !== 64'hF8)
            $display("FAIL pushq_post: R[4]=%h required f8", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_popq_rsp();
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1);
        total_cnt++;
        if (dstE !== 4'h4 || dstM !== 4'h4 || valA !== 64'hF8)
            $display("FAIL popq_pre: dstE=%h dstM=%h valA=%h required 4/4/f8", dstE, dstM, valA);
        else pass_cnt++;
        tick();
        dbg_addr = 4'h4; #1;
        total_cnt++;
        if (dbg_data !== 64'hDEAD)
            $display("FAIL popq_rsp_prio: R[4]=%h required dead", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_gating();
        drive(4'h6, 4'h2, 4'h5, 1'b0, 64'h55, 64'h0, 1'b0);
        total_cnt++;
        if (dstE !== 4'h5 || valA !== 64'h1234)
            $display("FAIL gate_idx: dstE=%h valA=%h required 5/1234", dstE, valA);
        else pass_cnt++;
        tick();
        dbg_addr = 4'h5; #1;
        total_cnt++;
        if (dbg_data !== 64'd0)
            $display("FAIL gate_hold: R[5]=%h required 0", dbg_data);
        else pass_cnt++;
        rst = 1'b1;
        drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h77, 64'h0, 1'b1);
        tick();
        rst = 1'b0;
        wb_en = 1'b0;
        for (int a = 0; a < 15; a++) begin
            dbg_addr = 4'(a);
            #1;
            total_cnt++;
            if (dbg_data !== 64'd0)
                $display("FAIL rst_with_wb[%0d]: got %h required 0", a, dbg_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [3:0] ra, rb, ic;
        for (int n = 0; n < 400; n++) begin
            ic = 4'($urandom_range(15));
            ra = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(14));
            rb = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(14));
            rst = ($urandom_range(40) == 0);
            dbg_addr = 4'($urandom_range(15));
            drive(ic, ra, rb, 1'($urandom_range(1)),
                  {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(4) != 0));
            total_cnt++;
            if (srcA !== ref_srca(ic, ra) || srcB !== ref_srcb(ic, rb) ||
                dstE !== ref_dste(ic, rb, cnd) || dstM !== ref_dstm(ic, ra))
                $display("FAIL rnd_idx[%0d]: ic=%h src=%h/%h dst=%h/%h required %h/%h %h/%h",
                         n, ic, srcA, srcB, dstE, dstM, ref_srca(ic, ra), ref_srcb(ic, rb),
                         ref_dste(ic, rb, cnd), ref_dstm(ic, ra));
            else pass_cnt++;
            total_cnt++;
            if (valA !== ref_read(ref_srca(ic, ra)) || valB !== ref_read(ref_srcb(ic, rb)) ||
                dbg_data !== ref_read(dbg_addr))
                $display("FAIL rnd_read[%0d]: valA=%h valB=%h dbg=%h required %h %h %h",
                         n, valA, valB, dbg_data, ref_read(ref_srca(ic, ra)),
                         ref_read(ref_srcb(ic, rb)), ref_read(dbg_addr));
            else pass_cnt++;
            tick();
        end
        rst = 1'b0;
        wb_en = 1'b0;
        for (int a = 0; a < 15; a++) begin
            dbg_addr = 4'(a);
            #1;
            total_cnt++;
            if (dbg_data !== model[a])
                $display("FAIL rnd_final[%0d]: got %h required %h", a, dbg_data, model[a]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = '0; valM = '0; wb_en = 1'b0; dbg_addr = 4'h0;
        for (int i = 0; i < 15; i++) model[i] = '0;
        @(negedge clk);
        test_reset();
        test_irmovq();
        test_cmov();
        test_pushq();
        test_popq_rsp();
        test_gating();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
